// File: rtl/llr_intri_ctrl.sv
// llr_intri_ctrl: loads one LLR frame into the intrinsic dual-port RAM, serves decoder reads,
// and frees the buffer on dec_done. Optional sticky protocol-error flag under INTRI_ERR_CHK_EN.
module llr_intri_ctrl #(
    parameter int unsigned LLR_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FRAME_LEN  = 192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LLR_WIDTH-1:0]  in_llr,
    output logic                  frame_rdy,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [LLR_WIDTH-1:0]  rd_data,
    input  logic                  dec_done,
    output logic [LLR_WIDTH-1:0]  ram_data,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    output logic                  ram_rden,
    input  logic [LLR_WIDTH-1:0]  ram_q,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, READ} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [ADDR_WIDTH-1:0] wcnt_nxt;
    logic                  xfer;
    logic                  rd_acc;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        xfer      = 1'b0;
        rd_acc    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    wcnt_nxt  = '0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    xfer = 1'b1;
                    // Counter holds on the last word so a full 2^ADDR_WIDTH frame never wraps.
                    if (wcnt == LAST_ADDR) begin
                        state_nxt = FLUSH;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
            FLUSH: state_nxt = READ;
            READ: begin
                if (dec_done) begin
                    state_nxt = IDLE;
                end else if (rd_req) begin
                    rd_acc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wcnt          <= '0;
            in_ready      <= 1'b0;
            frame_rdy     <= 1'b0;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
            ram_rden      <= 1'b0;
            ram_rdaddress <= '0;
            rd_valid      <= 1'b0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            in_ready  <= (state_nxt == LOAD);
            frame_rdy <= (state_nxt == READ);
            ram_wren  <= xfer;
            if (xfer) begin
                ram_wraddress <= wcnt;
                ram_data      <= in_llr;
            end
            ram_rden <= rd_acc;
            if (rd_acc) begin
                ram_rdaddress <= rd_addr;
            end
            // RAM output is registered on rden, so valid trails rden by one cycle regardless of state.
            rd_valid <= ram_rden;
        end
    end

    assign rd_data = ram_q;

`ifdef INTRI_ERR_CHK_EN
    localparam logic [ADDR_WIDTH:0] FRAME_LEN_EXT = (ADDR_WIDTH + 1)'(FRAME_LEN);

    logic err_evt;

    always_comb begin
        err_evt = 1'b0;
        if (rd_req && ((state != READ) || dec_done)) begin
            err_evt = 1'b1;
        end
        if (rd_req && (state == READ) && ({1'b0, rd_addr} >= FRAME_LEN_EXT)) begin
            err_evt = 1'b1;
        end
        if (start && (state != IDLE)) begin
            err_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_evt) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_llr_intri_ctrl.sv
// Directed bench for llr_intri_ctrl with a behavioural dual-port RAM (registered read on rden).
module tb_llr_intri_ctrl;

    localparam int unsigned LW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned FL = 192;

`ifdef INTRI_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_llr;
    logic          frame_rdy;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [LW-1:0] rd_data;
    logic          dec_done;
    logic [LW-1:0] ram_data;
    logic [AW-1:0] ram_wraddress;
    logic          ram_wren;
    logic [AW-1:0] ram_rdaddress;
    logic          ram_rden;
    logic [LW-1:0] ram_q;
    logic          err;

    llr_intri_ctrl #(.LLR_WIDTH(LW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
        .frame_rdy(frame_rdy), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .dec_done(dec_done),
        .ram_data(ram_data), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
        .ram_rdaddress(ram_rdaddress), .ram_rden(ram_rden), .ram_q(ram_q),
        .err(err)
    );

    logic [LW-1:0] mem [256];

    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_rdaddress];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } rd_vec_t;

    rd_vec_t rv [6];
    int total = 0;
    int bad   = 0;
    bit exp_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] wval(input int a, input bit flat);
        return flat ? 8'h7F : LW'(a + 10);
    endfunction

    task automatic chk_err();
        chk("err", 32'(err), 32'(ERR_EN && exp_err));
    endtask

    task automatic check_reset_vals();
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst frame_rdy", 32'(frame_rdy), 0);
        chk("rst rd_valid", 32'(rd_valid), 0);
        chk("rst err", 32'(err), 0);
        chk("rst ram_wren", 32'(ram_wren), 0);
        chk("rst ram_rden", 32'(ram_rden), 0);
        chk("rst ram_wraddress", 32'(ram_wraddress), 0);
        chk("rst ram_rdaddress", 32'(ram_rdaddress), 0);
        chk("rst ram_data", 32'(ram_data), 0);
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; rd_req = 1'b0; dec_done = 1'b0;
        #1;
        exp_err = 1'b0;
        check_reset_vals();
        @(posedge clk);
        #1;
        chk("rd_valid in reset", 32'(rd_valid), 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_frame(input bit throttle, input bit flat, input int stop_after);
        int   n   = 0;
        int   cyc = 0;
        logic rdy;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("in_ready after start", 32'(in_ready), 1);
        chk("frame_rdy during load", 32'(frame_rdy), 0);
        while (n < stop_after && cyc < 4 * int'(FL)) begin
            in_valid = throttle ? ~cyc[0] : 1'b1;
            in_llr   = wval(n, flat);
            rdy      = in_ready;
            tick();
            cyc++;
            if (in_valid && rdy) begin
                chk("wr wren", 32'(ram_wren), 1);
                chk("wr addr", 32'(ram_wraddress), 32'(n));
                chk("wr data", 32'(ram_data), 32'(wval(n, flat)));
                n++;
            end else begin
                chk("idle wren", 32'(ram_wren), 0);
            end
        end
        in_valid = 1'b0;
        chk("load word count", 32'(n), 32'(stop_after));
        if (stop_after == int'(FL)) begin
            chk("in_ready after last", 32'(in_ready), 0);
            chk("frame_rdy in flush", 32'(frame_rdy), 0);
            tick();
            chk("frame_rdy +2", 32'(frame_rdy), 1);
            chk("single wren pulse", 32'(ram_wren), 0);
        end
    endtask

    task automatic do_reads(input int first, input int n);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                rd_req  = 1'b1;
                rd_addr = rv[first + i].addr;
            end else begin
                rd_req = 1'b0;
            end
            tick();
            if (i < n) begin
                chk("rd rden", 32'(ram_rden), 1);
                chk("rd rdaddress", 32'(ram_rdaddress), 32'(rv[first + i].addr));
            end
            if (i >= 1) begin
                chk("rd_valid", 32'(rd_valid), 1);
                chk("rd_data", 32'(rd_data), 32'(rv[first + i - 1].data));
            end else begin
                chk("rd_valid early", 32'(rd_valid), 0);
            end
        end
        tick();
        chk("rd_valid after burst", 32'(rd_valid), 0);
        chk("rden after burst", 32'(ram_rden), 0);
    endtask

    initial begin
        rv[0] = '{8'd0,   8'd10};
        rv[1] = '{8'd5,   8'd15};
        rv[2] = '{8'd191, 8'd201};
        rv[3] = '{8'd0,   8'h7F};
        rv[4] = '{8'd191, 8'h7F};
        rv[5] = '{8'd100, 8'd110};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_llr = '0;
        rd_req = 1'b0; rd_addr = '0; dec_done = 1'b0;
        #50;
        check_reset_vals();
        #50;
        rst_n = 1'b1;
        tick();

        // rd_req in IDLE: ignored, flags an error when checking is built
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        exp_err = 1'b1;
        chk("idle req rden", 32'(ram_rden), 0);
        chk_err();
        tick();
        tick();
        chk("idle req rd_valid", 32'(rd_valid), 0);
        chk_err();
        do_reset();

        load_frame(1'b0, 1'b0, int'(FL));
        do_reads(0, 3);
        do_reads(5, 1);

        // out-of-range address is still forwarded to the RAM
        rd_req = 1'b1;
        rd_addr = 8'd200;
        tick();
        rd_req = 1'b0;
        exp_err = 1'b1;
        chk("oor rden", 32'(ram_rden), 1);
        chk("oor rdaddress", 32'(ram_rdaddress), 200);
        chk_err();
        tick();
        chk("oor rd_valid", 32'(rd_valid), 1);
        tick();
        chk_err();

        // start in READ is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start in READ frame_rdy", 32'(frame_rdy), 1);
        chk("start in READ in_ready", 32'(in_ready), 0);
        tick();
        chk("start in READ frame_rdy 2", 32'(frame_rdy), 1);

        // in-flight read survives release; colliding request is dropped
        rd_req = 1'b1;
        rd_addr = 8'd5;
        tick();
        rd_addr = 8'd3;
        dec_done = 1'b1;
        tick();
        rd_req = 1'b0;
        dec_done = 1'b0;
        chk("release frame_rdy", 32'(frame_rdy), 0);
        chk("collision rden", 32'(ram_rden), 0);
        chk("inflight rd_valid", 32'(rd_valid), 1);
        chk("inflight rd_data", 32'(rd_data), 15);
        chk("release in_ready", 32'(in_ready), 0);
        tick();
        chk("collision rd_valid", 32'(rd_valid), 0);
        chk_err();

        load_frame(1'b0, 1'b1, int'(FL));
        do_reads(3, 2);
        chk_err();

        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        chk("release2 frame_rdy", 32'(frame_rdy), 0);
        load_frame(1'b1, 1'b0, int'(FL));
        do_reads(0, 3);
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;

        // reset mid-load, then restart from address 0
        load_frame(1'b0, 1'b0, 50);
        do_reset();
        chk("post-reset frame_rdy", 32'(frame_rdy), 0);
        load_frame(1'b0, 1'b0, int'(FL));
        do_reads(0, 3);

        // reset with a read in flight: no rd_valid may emerge
        rd_req = 1'b1;
        rd_addr = 8'd5;
        tick();
        rd_req = 1'b0;
        chk("pre-reset rden", 32'(ram_rden), 1);
        do_reset();
        chk("flushed rd_valid", 32'(rd_valid), 0);
        chk_err();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
